// File: rtl/x74161_dual.sv
// Dual synchronous 4-bit counter model with 74161/74163 behaviour.
// The modelled TTL clocks are level inputs; each counter advances on the
// detected rising edge of its level, sampled in the single clk domain.
module x74161_dual #(
  parameter int WIDTH    = 32'sd4,
  parameter int CLR_SYNC = 32'sd0,
  parameter int CASCADE  = 32'sd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cclk1,
  input  logic             clr1_n,
  input  logic             ld1_n,
  input  logic             enp1,
  input  logic             ent1,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q1,
  output logic             rco1,
  input  logic             cclk2,
  input  logic             clr2_n,
  input  logic             ld2_n,
  input  logic             enp2,
  input  logic             ent2,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] q2,
  output logic             rco2
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit ASYNC_CLR = (CLR_SYNC == 32'sd0);
  localparam bit CASC      = (CASCADE != 32'sd0);

  logic [WIDTH-1:0] cnt1_r;
  logic [WIDTH-1:0] cnt2_r;
  logic             prev1_r;
  logic             prev2_r;
  logic             edge1_s;
  logic             edge2_s;
  logic             ent1_eff_s;
  logic             ent2_eff_s;

  // Next count for one channel: async clear dominates every clk, otherwise
  // a TTL edge applies sync clear, load, count or hold in that order.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cnt,
    input logic             edge_hit,
    input logic             clr_n,
    input logic             ld_n,
    input logic             enp,
    input logic             ent_eff,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] nxt;
    nxt = cnt;
    if (ASYNC_CLR && !clr_n) begin
      nxt = ZERO;
    end else if (edge_hit) begin
      if (!ASYNC_CLR && !clr_n) begin
        nxt = ZERO;
      end else if (!ld_n) begin
        nxt = d;
      end else if (enp && ent_eff) begin
        nxt = cnt + ONE;
      end else begin
        nxt = cnt;
      end
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // Channel 1 edge detect, clear override on q, and terminal-count carry.
  always_comb begin
    edge1_s    = cclk1 & ~prev1_r;
    ent1_eff_s = ent1;
    if (ASYNC_CLR && !clr1_n) begin
      q1 = ZERO;
    end else begin
      q1 = cnt1_r;
    end
    rco1 = ent1_eff_s & (q1 == ONES);
  end

  // Channel 2 edge detect, optional carry chaining from channel 1, q and carry.
  always_comb begin
    edge2_s = cclk2 & ~prev2_r;
    if (CASC) begin
      ent2_eff_s = ent2 & rco1;
    end else begin
      ent2_eff_s = ent2;
    end
    if (ASYNC_CLR && !clr2_n) begin
      q2 = ZERO;
    end else begin
      q2 = cnt2_r;
    end
    rco2 = ent2_eff_s & (q2 == ONES);
  end

  // Counter state; prev resets high so a level already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1_r  <= ZERO;
      cnt2_r  <= ZERO;
      prev1_r <= 1'b1;
      prev2_r <= 1'b1;
    end else begin
      prev1_r <= cclk1;
      prev2_r <= cclk2;
      cnt1_r  <= next_count(cnt1_r, edge1_s, clr1_n, ld1_n, enp1, ent1_eff_s, d1);
      cnt2_r  <= next_count(cnt2_r, edge2_s, clr2_n, ld2_n, enp2, ent2_eff_s, d2);
    end
  end

endmodule

// File: tb/tb_x74161_dual.sv
// Self-checking bench for x74161_dual: two configurations side by side
// (dut_a: async clear, no cascade; dut_b: sync clear, cascaded carry),
// directed sequences plus randomized stimulus against a behavioural model.
module tb_x74161_dual;

  logic       clk = 1'b0;
  logic       reset, cclk1, clr1_n, ld1_n, enp1, ent1;
  logic       cclk2, clr2_n, ld2_n, enp2, ent2;
  logic [3:0] d1, d2;
  logic [3:0] q1_a, q2_a, q1_b, q2_b;
  logic       rco1_a, rco2_a, rco1_b, rco2_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model state: count per [dut][channel] and last-seen TTL clock level.
  int m_cnt [2][2];
  bit m_prev[2][2];

  always #5 clk = ~clk;

  x74161_dual #(.WIDTH(4), .CLR_SYNC(0), .CASCADE(0)) dut_a (
    .clk(clk), .reset(reset),
    .cclk1(cclk1), .clr1_n(clr1_n), .ld1_n(ld1_n), .enp1(enp1), .ent1(ent1),
    .d1(d1), .q1(q1_a), .rco1(rco1_a),
    .cclk2(cclk2), .clr2_n(clr2_n), .ld2_n(ld2_n), .enp2(enp2), .ent2(ent2),
    .d2(d2), .q2(q2_a), .rco2(rco2_a)
  );

  x74161_dual #(.WIDTH(4), .CLR_SYNC(1), .CASCADE(1)) dut_b (
    .clk(clk), .reset(reset),
    .cclk1(cclk1), .clr1_n(clr1_n), .ld1_n(ld1_n), .enp1(enp1), .ent1(ent1),
    .d1(d1), .q1(q1_b), .rco1(rco1_b),
    .cclk2(cclk2), .clr2_n(clr2_n), .ld2_n(ld2_n), .enp2(enp2), .ent2(ent2),
    .d2(d2), .q2(q2_b), .rco2(rco2_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Visible count: dut 0 forces q to zero while clear is low.
  function automatic int mq(input int dv, input int ch);
    bit clrn;
    clrn = (ch == 0) ? clr1_n : clr2_n;
    if (dv == 0 && !clrn) return 0;
    return m_cnt[dv][ch];
  endfunction

  function automatic bit m_ent_eff(input int dv, input int ch);
    if (ch == 0) return ent1;
    if (dv == 1) return ent2 && (ent1 && mq(dv, 0) == 15);
    return ent2;
  endfunction

  function automatic bit mrco(input int dv, input int ch);
    return m_ent_eff(dv, ch) && (mq(dv, ch) == 15);
  endfunction

  // Apply one system clock to the model using the inputs held across the edge.
  task automatic model_update();
    bit ent_eff[2][2];
    for (int dv = 0; dv < 2; dv++)
      for (int ch = 0; ch < 2; ch++)
        ent_eff[dv][ch] = m_ent_eff(dv, ch);
    for (int dv = 0; dv < 2; dv++) begin
      for (int ch = 0; ch < 2; ch++) begin
        bit lvl, clrn, ldn, enp, rise;
        int dat;
        lvl  = (ch == 0) ? cclk1  : cclk2;
        clrn = (ch == 0) ? clr1_n : clr2_n;
        ldn  = (ch == 0) ? ld1_n  : ld2_n;
        enp  = (ch == 0) ? enp1   : enp2;
        dat  = (ch == 0) ? int'(d1) : int'(d2);
        if (reset) begin
          m_cnt[dv][ch]  = 0;
          m_prev[dv][ch] = 1'b1;
        end else begin
          rise = lvl && !m_prev[dv][ch];
          m_prev[dv][ch] = lvl;
          if (dv == 0 && !clrn) m_cnt[dv][ch] = 0;
          else if (rise) begin
            if (dv == 1 && !clrn) m_cnt[dv][ch] = 0;
            else if (!ldn) m_cnt[dv][ch] = dat;
            else if (enp && ent_eff[dv][ch]) m_cnt[dv][ch] = (m_cnt[dv][ch] + 1) % 16;
          end
        end
      end
    end
  endtask

  // Called just after a negedge with inputs set: compare, then take one clk.
  task automatic step();
    #1;
    if (chk_en) begin
      check_eq("a_q1",   32'(q1_a),   32'(mq(0, 0)));
      check_eq("a_q2",   32'(q2_a),   32'(mq(0, 1)));
      check_eq("a_rco1", 32'(rco1_a), 32'(mrco(0, 0)));
      check_eq("a_rco2", 32'(rco2_a), 32'(mrco(0, 1)));
      check_eq("b_q1",   32'(q1_b),   32'(mq(1, 0)));
      check_eq("b_q2",   32'(q2_b),   32'(mq(1, 1)));
      check_eq("b_rco1", 32'(rco1_b), 32'(mrco(1, 0)));
      check_eq("b_rco2", 32'(rco2_b), 32'(mrco(1, 1)));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse1(input int hi, input int lo);
    cclk1 = 1'b1;
    repeat (hi) step();
    cclk1 = 1'b0;
    repeat (lo) step();
  endtask

  task automatic pulse_both(input int hi, input int lo);
    cclk1 = 1'b1; cclk2 = 1'b1;
    repeat (hi) step();
    cclk1 = 1'b0; cclk2 = 1'b0;
    repeat (lo) step();
  endtask

  initial begin
    reset = 1'b1; cclk1 = 1'b1; cclk2 = 1'b1;
    clr1_n = 1'b1; ld1_n = 1'b1; enp1 = 1'b0; ent1 = 1'b0; d1 = 4'h0;
    clr2_n = 1'b1; ld2_n = 1'b1; enp2 = 1'b0; ent2 = 1'b0; d2 = 4'h0;
    @(negedge clk);

    // Reset with cclk1 held high: no false edge at release.
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    check_eq("rst_q1_a",   32'(q1_a),   32'd0);
    check_eq("rst_q1_b",   32'(q1_b),   32'd0);
    check_eq("rst_rco1_a", 32'(rco1_a), 32'd0);

    // 17 counting pulses: 1..15, 0, 1 with carry only at 15.
    enp1 = 1'b1; ent1 = 1'b1; cclk1 = 1'b0;
    step();
    for (int i = 0; i < 17; i++) begin
      pulse1(2, 2);
      check_eq("cnt_q1_a",   32'(q1_a),   32'((i + 1) % 16));
      check_eq("cnt_rco1_a", 32'(rco1_a), 32'(((i + 1) % 16) == 15));
      check_eq("cnt_q1_b",   32'(q1_b),   32'((i + 1) % 16));
    end

    // Load 0xA then count 6 edges to 0.
    ld1_n = 1'b0; d1 = 4'hA;
    pulse1(2, 2);
    check_eq("ld_q1_a", 32'(q1_a), 32'hA);
    ld1_n = 1'b1;
    repeat (6) pulse1(2, 2);
    check_eq("ldcnt_q1_a", 32'(q1_a), 32'h0);
    check_eq("ldcnt_q1_b", 32'(q1_b), 32'h0);

    // Load with count enable off still loads, and then holds.
    enp1 = 1'b0; ld1_n = 1'b0; d1 = 4'hA;
    pulse1(2, 2);
    ld1_n = 1'b1;
    pulse1(2, 2);
    check_eq("ldnoen_q1_a", 32'(q1_a), 32'hA);
    check_eq("ldnoen_q1_b", 32'(q1_b), 32'hA);

    // Clear low with no edge: async drops at once, sync holds.
    enp1 = 1'b1; ld1_n = 1'b0; d1 = 4'h7;
    pulse1(2, 2);
    ld1_n = 1'b1;
    clr1_n = 1'b0;
    #1;
    check_eq("aclr_now_q1_a", 32'(q1_a), 32'd0);
    step(); step();
    check_eq("aclr_q1_a", 32'(q1_a), 32'd0);
    check_eq("sclr_hold_q1_b", 32'(q1_b), 32'd7);
    clr1_n = 1'b1;
    step(); step();
    check_eq("aclr_rel_q1_a", 32'(q1_a), 32'd0);
    pulse1(2, 2);
    check_eq("aclr_next_q1_a", 32'(q1_a), 32'd1);
    check_eq("sclr_none_q1_b", 32'(q1_b), 32'd8);

    // Clear held low across an edge: sync clear takes effect on that edge.
    ld1_n = 1'b0; d1 = 4'h7;
    pulse1(2, 2);
    ld1_n = 1'b1; clr1_n = 1'b0;
    pulse1(2, 2);
    check_eq("sclr_edge_q1_b", 32'(q1_b), 32'd0);
    check_eq("aclr_edge_q1_a", 32'(q1_a), 32'd0);
    clr1_n = 1'b1;
    step();

    // Cascade: 32 shared edges; dut_b channel 2 advances only past q1 = 15.
    cclk1 = 1'b0; cclk2 = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    enp1 = 1'b1; ent1 = 1'b1; enp2 = 1'b1; ent2 = 1'b1;
    repeat (32) pulse_both(1, 1);
    check_eq("casc_q1_b", 32'(q1_b), 32'd0);
    check_eq("casc_q2_b", 32'(q2_b), 32'd2);
    check_eq("nocasc_q2_a", 32'(q2_a), 32'd0);

    // Reset mid-count with the TTL clocks going high.
    ld1_n = 1'b0; ld2_n = 1'b0; d1 = 4'd9; d2 = 4'd3;
    pulse_both(1, 1);
    ld1_n = 1'b1; ld2_n = 1'b1;
    check_eq("pre_rst_q1_b", 32'(q1_b), 32'd9);
    check_eq("pre_rst_q2_b", 32'(q2_b), 32'd3);
    cclk1 = 1'b1; cclk2 = 1'b1; reset = 1'b1;
    step();
    check_eq("mrst_q1_b", 32'(q1_b), 32'd0);
    check_eq("mrst_q2_b", 32'(q2_b), 32'd0);
    check_eq("mrst_rco1_b", 32'(rco1_b), 32'd0);
    reset = 1'b0;
    repeat (3) step();
    check_eq("mrst_rel_q1_a", 32'(q1_a), 32'd0);
    check_eq("mrst_rel_q2_b", 32'(q2_b), 32'd0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 59) == 0);
      cclk1  = 1'($urandom_range(0, 1));
      cclk2  = ($urandom_range(0, 3) == 0) ? cclk1 : 1'($urandom_range(0, 1));
      clr1_n = ($urandom_range(0, 11) != 0);
      clr2_n = ($urandom_range(0, 11) != 0);
      ld1_n  = ($urandom_range(0, 7) != 0);
      ld2_n  = ($urandom_range(0, 7) != 0);
      enp1   = ($urandom_range(0, 4) != 0);
      ent1   = ($urandom_range(0, 4) != 0);
      enp2   = ($urandom_range(0, 4) != 0);
      ent2   = ($urandom_range(0, 4) != 0);
      d1     = 4'($urandom_range(0, 15));
      d2     = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
